life_cell_gen: RTL and testbench
================================

// Module: life_cell_gen
// PURPOSE
//  Parametrised Game-of-Life cell for the LED-array life grid: one instance per pixel.
//  Rule masks are programmable (B/S notation); optional "Generations" decay states; per-cell age counter.
//  Generation advance is gated by a one-cycle step strobe; setup mode edits cells via cursor select + edge-detected toggle.
//  Sits between the grid neighbour wiring and the LED driver (alive -> green, dying -> red).
// PARAMETERS
//  BIRTH_MASK    9'b0_0000_1000  bit k=1: dead cell with k live neighbours is born (default B3)
//  SURVIVE_MASK  9'b0_0000_1100  bit k=1: live cell with k live neighbours survives (default S23)
//  DECAY_STATES  0               dying generations after death; 0 = classic two-state life
//  AGE_W         4               width of age counter (saturating)
// PORTS
//  Clock       in   1      system clock
//  Reset_n     in   1      synchronous, active-low reset
//  nbr         in   8      neighbour alive bits {nw,w,sw,s,se,e,ne,n}
//  step        in   1      one-cycle strobe: advance one generation
//  setup       in   1      1 = setup (edit) mode, 0 = run mode
//  light_sel   in   1      cursor is on this cell
//  toggle      in   1      edit key, level; acted on at rising edge only
//  alive       out  1      cell is live (also fed to neighbours)
//  dying       out  1      cell in a decay state (never counted as live)
//  age         out  AGE_W  generations survived since birth/toggle-on, saturating
//  changed     out  1      one-cycle pulse: alive changed on the last update
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low: Reset_n=0 at posedge -> state DEAD, alive=0, dying=0,
//    age=0, changed=0, toggle_q=0, decay count=0. Reset mid-generation discards that update.
//  - cnt = popcount(nbr), 0..8, 4 bits. All outputs registered; effect visible 1 cycle after the causing edge.
//  - States: DEAD, ALIVE, DYING (unreachable when DECAY_STATES=0). setup is a mode, not a state.
//  - Toggle edge: tog_rise = toggle & ~toggle_q; toggle_q sampled every cycle (also outside setup).
//  - Priority per cycle: reset > setup > step > hold.
//  - Setup (setup=1): step ignored. light_sel & tog_rise: DEAD->ALIVE (age=0), ALIVE->DEAD, DYING->DEAD.
//    Entering setup from DYING forces DEAD on the first setup cycle. Leaving setup: state kept, no update that cycle.
//  - Run (setup=0, step=1):
//      DEAD : BIRTH_MASK[cnt] -> ALIVE, age=0; else stay.
//      ALIVE: SURVIVE_MASK[cnt] -> stay, age=min(age+1, 2^AGE_W-1);
//             else DECAY_STATES=0 -> DEAD, else DYING with dcnt=DECAY_STATES-1.
//      DYING: dcnt==0 -> DEAD else dcnt-- ; cannot be born while DYING.
//  - Run, step=0: hold everything; tog_rise ignored.
//  - changed=1 for exactly one cycle after any update that flips alive (setup or run); else 0.
//  - age=0 whenever not ALIVE. dcnt width = $clog2(DECAY_STATES+1), min 1.
//  - cnt > 8 impossible; masks indexed 0..8 only.
// STRUCTURE
//  - life_pkg: typedef enum logic [1:0] {DEAD, ALIVE, DYING} cell_state_t; NBR_N=8;
//    B3_MASK / S23_MASK constants used as parameter defaults.
//  - Sub-module nbr_popcount: nbr[7:0] -> cnt[3:0], purely combinational, shared with grid debug logic.
//  - life_cell_gen: state reg, decay counter, age counter, toggle_q, changed reg; single always_ff + always_comb next-state.
// TESTING
//  1. Reset_n=0 with nbr=8'hFF, step=1 -> alive=0, dying=0, age=0, changed=0; release -> still DEAD until step.
//  2. Default masks, DEAD, nbr=8'b0000_0111, step pulse -> next cycle alive=1, age=0, changed=1; following cycle changed=0.
//  3. ALIVE, nbr=8'b0000_0011, 20 step pulses (AGE_W=4) -> alive stays 1, age saturates at 15; nbr=8'h01, step -> alive=0, age=0.
//  4. DECAY_STATES=2: ALIVE, nbr=0, step -> dying=1; 2 more steps with nbr=8'h07 -> dying=1 then 0; no birth until DEAD,
//     next step births.
//  5. setup=1, light_sel=1, toggle held high 10 cycles -> exactly one flip; step pulses during setup -> no change;
//     light_sel=0 + toggle edge -> no change.
//  6. setup=1 and step=1 same cycle on DEAD cell with cnt=3 -> stays DEAD; DYING cell entering setup -> DEAD next cycle.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the life grid cells: cell state encoding,
// neighbour count width and the classic B3/S23 rule masks.
package life_pkg;

  typedef enum logic [1:0] {
    DEAD  = 2'd0,
    ALIVE = 2'd1,
    DYING = 2'd2
  } cell_state_t;

  localparam int NBR_N = 8;
  localparam logic [8:0] B3_MASK  = 9'b0_0000_1000;
  localparam logic [8:0] S23_MASK = 9'b0_0000_1100;

  function automatic logic [3:0] popcount8(input logic [NBR_N-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int k = 0; k < NBR_N; k++) begin
      c = c + {3'd0, v[k]};
    end
    return c;
  endfunction

endpackage

// File: rtl/nbr_popcount.sv
// Live-neighbour counter: number of set bits in the 8 neighbour alive lines.
// Purely combinational so the grid debug logic can reuse it.
module nbr_popcount
  import life_pkg::*;
(
  input  logic [NBR_N-1:0] i_nbr,
  output logic [3:0]       o_cnt
);

  assign o_cnt = popcount8(i_nbr);

endmodule

// File: rtl/life_cell_gen.sv
// One Game-of-Life pixel: programmable B/S rules, optional decay generations,
// saturating age counter and a setup mode with cursor-selected edge toggle.
module life_cell_gen
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK,
  parameter int         DECAY_STATES = 0,
  parameter int         AGE_W        = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_nbr,
  input  logic             i_step,
  input  logic             i_setup,
  input  logic             i_light_sel,
  input  logic             i_toggle,
  output logic             o_alive,
  output logic             o_dying,
  output logic [AGE_W-1:0] o_age,
  output logic             o_changed
);

  localparam int DCNT_W = (DECAY_STATES > 0) ? $clog2(DECAY_STATES + 1) : 1;
  localparam logic [AGE_W-1:0]  AGE_MAX   = {AGE_W{1'b1}};
  localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
  localparam logic [DCNT_W-1:0] DCNT_INIT = (DECAY_STATES > 0) ? DCNT_W'(DECAY_STATES - 1) : DCNT_ZERO;

  cell_state_t       r_state;
  logic [DCNT_W-1:0] r_dcnt;
  logic [AGE_W-1:0]  r_age;
  logic              r_toggle_q;
  logic              r_alive;
  logic              r_dying;
  logic              r_changed;

  cell_state_t       w_state_nxt;
  logic [DCNT_W-1:0] w_dcnt_nxt;
  logic [AGE_W-1:0]  w_age_nxt;
  logic [3:0]        w_cnt;
  logic              w_tog_rise;

  nbr_popcount u_popcount (
    .i_nbr (i_nbr),
    .o_cnt (w_cnt)
  );

  assign w_tog_rise = i_toggle & ~r_toggle_q;

  // Next-state: setup edits take precedence over a generation step.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_age_nxt   = r_age;
    if (i_setup) begin
      if (r_state == DYING) begin
        w_state_nxt = DEAD;
        w_dcnt_nxt  = DCNT_ZERO;
      end else if (i_light_sel && w_tog_rise) begin
        w_state_nxt = (r_state == ALIVE) ? DEAD : ALIVE;
        w_age_nxt   = {AGE_W{1'b0}};
      end else begin
        w_state_nxt = r_state;
      end
    end else if (i_step) begin
      case (r_state)
        DEAD: begin
          if (BIRTH_MASK[w_cnt]) begin
            w_state_nxt = ALIVE;
            w_age_nxt   = {AGE_W{1'b0}};
          end else begin
            w_state_nxt = DEAD;
          end
        end
        ALIVE: begin
          if (SURVIVE_MASK[w_cnt]) begin
            w_age_nxt = (r_age == AGE_MAX) ? AGE_MAX : r_age + {{(AGE_W-1){1'b0}}, 1'b1};
          end else if (DECAY_STATES == 0) begin
            w_state_nxt = DEAD;
            w_age_nxt   = {AGE_W{1'b0}};
          end else begin
            w_state_nxt = DYING;
            w_dcnt_nxt  = DCNT_INIT;
            w_age_nxt   = {AGE_W{1'b0}};
          end
        end
        DYING: begin
          if (r_dcnt == DCNT_ZERO) begin
            w_state_nxt = DEAD;
          end else begin
            w_dcnt_nxt = r_dcnt - {{(DCNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          w_state_nxt = DEAD;
          w_dcnt_nxt  = DCNT_ZERO;
          w_age_nxt   = {AGE_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, counters, toggle history and registered LED outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= DEAD;
      r_dcnt     <= DCNT_ZERO;
      r_age      <= {AGE_W{1'b0}};
      r_toggle_q <= 1'b0;
      r_alive    <= 1'b0;
      r_dying    <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_age      <= w_age_nxt;
      r_toggle_q <= i_toggle;
      r_alive    <= (w_state_nxt == ALIVE);
      r_dying    <= (w_state_nxt == DYING);
      r_changed  <= (w_state_nxt == ALIVE) != (r_state == ALIVE);
    end
  end

  assign o_alive   = r_alive;
  assign o_dying   = r_dying;
  assign o_age     = r_age;
  assign o_changed = r_changed;

endmodule

// File: tb/tb_life_cell_gen.sv
// Scenario bench for life_cell_gen: a classic two-state cell and a two-generation
// decay cell share stimulus; expected {alive,dying,age,changed} go through a queue.
module tb_life_cell_gen;

  logic       clk = 1'b0;
  logic       rst_n, step, setup, light_sel, toggle;
  logic [7:0] nbr;
  logic       alive, dying, changed;
  logic [3:0] age;
  logic       alive_d, dying_d, changed_d;
  logic [3:0] age_d;

  logic [6:0] exp_q[$];
  logic [6:0] e;
  int         n_vec = 0;
  int         n_err = 0;

  wire [6:0] w_obs   = {alive, dying, age, changed};
  wire [6:0] w_obs_d = {alive_d, dying_d, age_d, changed_d};

  always #5 clk = ~clk;

  life_cell_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_nbr(nbr), .i_step(step), .i_setup(setup),
    .i_light_sel(light_sel), .i_toggle(toggle),
    .o_alive(alive), .o_dying(dying), .o_age(age), .o_changed(changed)
  );

  life_cell_gen #(.DECAY_STATES(2)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_nbr(nbr), .i_step(step), .i_setup(setup),
    .i_light_sel(light_sel), .i_toggle(toggle),
    .o_alive(alive_d), .o_dying(dying_d), .o_age(age_d), .o_changed(changed_d)
  );

  task automatic drive(input logic r, input logic [7:0] n, input logic s,
                       input logic su, input logic ls, input logic t);
    rst_n = r; nbr = n; step = s; setup = su; light_sel = ls; toggle = t;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic       rr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] nb [4] = '{8'hFF, 8'h07, 8'hFF, 8'h07};
    logic       st [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(rr[i], nb[i], st[i], 1'b0, 1'b0, 1'b0);
      exp_q.push_back(7'b000_0000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL reset[%0d]: got %b want %b", i, w_obs, e); end
      n_vec++;
      if (w_obs_d !== e) begin n_err++; $display("FAIL reset_decay[%0d]: got %b want %b", i, w_obs_d, e); end
    end
  endtask

  task automatic test_birth();
    logic [7:0] nb [4] = '{8'h07, 8'h07, 8'h07, 8'hFF};
    logic       st [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] ex [4] = '{7'b1_0_0000_1, 7'b1_0_0000_0, 7'b1_0_0001_0, 7'b1_0_0001_0};
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, nb[i], st[i], 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL birth[%0d]: got %b want %b", i, w_obs, e); end
    end
  endtask

  task automatic test_back_to_back_age();
    int a;
    pulse_reset();
    for (int i = 0; i < 23; i++) begin
      if (i == 0) begin
        drive(1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(7'b1_0_0000_1);
      end else if (i <= 20) begin
        a = (i > 15) ? 15 : i;
        drive(1'b1, 8'b0000_0011, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 4'(a), 1'b0});
      end else if (i == 21) begin
        drive(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(7'b0_0_0000_1);
      end else begin
        drive(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(7'b0_0_0000_0);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL age[%0d]: got %b want %b", i, w_obs, e); end
    end
  endtask

  task automatic test_decay();
    logic [7:0] nb [6] = '{8'h07, 8'h00, 8'h07, 8'h07, 8'h07, 8'h07};
    logic       st [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [6:0] ex [6] = '{7'b1_0_0000_1, 7'b0_1_0000_1, 7'b0_1_0000_0,
                           7'b0_1_0000_0, 7'b0_0_0000_0, 7'b1_0_0000_1};
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, nb[i], st[i], 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs_d !== e) begin n_err++; $display("FAIL decay[%0d]: got %b want %b", i, w_obs_d, e); end
    end
  endtask

  task automatic test_setup_toggle();
    // columns: setup, light_sel, toggle, step
    logic [3:0] ctl [9] = '{4'b1100, 4'b1010, 4'b1110, 4'b1100, 4'b1110,
                            4'b0000, 4'b0110, 4'b1110, 4'b1100};
    logic [6:0] ex  [9] = '{7'b1_0_0000_0, 7'b1_0_0000_0, 7'b1_0_0000_0, 7'b1_0_0000_0,
                            7'b0_0_0000_1, 7'b0_0_0000_0, 7'b0_0_0000_0, 7'b0_0_0000_0,
                            7'b0_0_0000_0};
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_q.push_back((i == 0) ? 7'b1_0_0000_1 : 7'b1_0_0000_0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL toggle_hold[%0d]: got %b want %b", i, w_obs, e); end
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'h07, ctl[i][0], ctl[i][3], ctl[i][2], ctl[i][1]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs !== e) begin n_err++; $display("FAIL toggle_seq[%0d]: got %b want %b", i, w_obs, e); end
    end
  endtask

  task automatic test_setup_priority();
    // columns: setup, light_sel, step, nbr
    logic [2:0] ctl [6] = '{3'b101, 3'b111, 3'b001, 3'b001, 3'b100, 3'b101};
    logic [7:0] nb  [6] = '{8'h07, 8'h07, 8'h07, 8'h00, 8'h00, 8'h07};
    logic [6:0] ex  [6] = '{7'b0_0_0000_0, 7'b0_0_0000_0, 7'b1_0_0000_1,
                            7'b0_1_0000_1, 7'b0_0_0000_0, 7'b0_0_0000_0};
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, nb[i], ctl[i][0], ctl[i][2], ctl[i][1], 1'b0);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if (w_obs_d !== e) begin n_err++; $display("FAIL setup_prio[%0d]: got %b want %b", i, w_obs_d, e); end
    end
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_birth();
    test_back_to_back_age();
    test_decay();
    test_setup_toggle();
    test_setup_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
